// File: rtl/ppi_pkg.sv
// Shared helpers for polyphase lane packing: phase-counter width and lane slice offsets.
package ppi_pkg;

  // Phase counter width: max(1, clog2(n)) so a 1- or 2-lane design still gets one bit.
  function automatic int unsigned phase_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB position of lane 'lane' in a packed frame of 'w'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned w);
    return lane * w;
  endfunction

endpackage

// File: rtl/commutator_demux_dff.sv
// Enabled register for one output lane of the frame.
// Ports: i_clk, i_rst (async active-high), i_ena (load strobe), i_d (lane in), o_q (lane out).
module commutator_demux_dff #(
  parameter int unsigned gp_width = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_ena,
  input  logic [gp_width-1:0] i_d,
  output logic [gp_width-1:0] o_q
);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_q <= '0;
    end else if (i_ena) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/commutator_demux.sv
// Serial-to-parallel commutator: fans accepted samples out over gp_nr_phases lanes
// and presents a complete frame on o_data once the last lane is filled.
// Ports: i_clk, i_rst (async active-high), i_ena (global enable), i_valid (sample strobe),
//        i_sync (frame restart), i_data (sample), o_data (frame), o_valid (frame pulse),
//        o_phase (next lane to fill), o_sync_err (sticky partial-frame discard flag).
module commutator_demux
  import ppi_pkg::*;
#(
  parameter int unsigned gp_data_width = 8,
  parameter int unsigned gp_nr_phases  = 4
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  input  logic                                  i_ena,
  input  logic                                  i_valid,
  input  logic                                  i_sync,
  input  logic [gp_data_width-1:0]              i_data,
  output logic [gp_nr_phases*gp_data_width-1:0] o_data,
  output logic                                  o_valid,
  output logic [phase_w(gp_nr_phases)-1:0]      o_phase,
  output logic                                  o_sync_err
);

  localparam int unsigned W  = gp_data_width;
  localparam int unsigned PW = phase_w(gp_nr_phases);
  // The last lane bypasses staging and is taken straight from i_data.
  localparam int unsigned NS = gp_nr_phases - 1;

  logic [PW-1:0] phase_q;
  logic [W-1:0]  stage_q [NS];
  logic          accept_c;
  logic          last_c;
  logic          frame_done_c;

  assign accept_c     = i_ena & i_valid;
  assign last_c       = (phase_q == PW'(gp_nr_phases - 1));
  // A sync coinciding with the last sample restarts the frame instead of completing it.
  assign frame_done_c = accept_c & ~i_sync & last_c;
  assign o_phase      = phase_q;

  // Phase counter; wraps explicitly so unused codes of a non-power-of-two count are unreachable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      phase_q <= '0;
    end else if (i_ena) begin
      if (i_sync) begin
        phase_q <= accept_c ? PW'(1) : '0;
      end else if (accept_c) begin
        phase_q <= last_c ? '0 : phase_q + PW'(1);
      end
    end
  end

  // Staging lanes; sync clears them and a coincident sample lands in lane 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < int'(NS); p++) begin
        stage_q[p] <= '0;
      end
    end else if (i_ena) begin
      for (int p = 0; p < int'(NS); p++) begin
        if (i_sync) begin
          stage_q[p] <= (accept_c && p == 0) ? i_data : '0;
        end else if (accept_c && phase_q == PW'(p)) begin
          stage_q[p] <= i_data;
        end
      end
    end
  end

  // Frame pulse is not gated by i_ena so it always drops after one cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
    end else begin
      o_valid <= frame_done_c;
    end
  end

  // Sticky flag for a sync that throws away a partially filled frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sync_err <= 1'b0;
    end else if (i_ena && i_sync && phase_q != '0) begin
      o_sync_err <= 1'b1;
    end
  end

  // Output frame register, one enabled lane register each.
  for (genvar p = 0; p < gp_nr_phases; p++) begin : g_lane
    logic [W-1:0] d_c;
    if (p == gp_nr_phases - 1) begin : g_direct
      assign d_c = i_data;
    end else begin : g_staged
      assign d_c = stage_q[p];
    end
    commutator_demux_dff #(.gp_width(W)) u_dff (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_ena (frame_done_c),
      .i_d   (d_c),
      .o_q   (o_data[lane_lsb(p, W) +: W])
    );
  end

endmodule

// File: tb/tb_commutator_demux.sv
module tb_commutator_demux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance drive: 0 -> 4 lanes, 1 -> 3 lanes, 2 -> 2 lanes.
  logic       ena [3];
  logic       vld [3];
  logic       syn [3];
  logic [7:0] din [3];

  logic [31:0] d0;
  logic [23:0] d1;
  logic [15:0] d2;
  logic [1:0]  p0, p1;
  logic [0:0]  p2;
  logic        v0, v1, v2, e0, e1, e2;

  commutator_demux #(.gp_data_width(8), .gp_nr_phases(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena[0]), .i_valid(vld[0]), .i_sync(syn[0]),
    .i_data(din[0]), .o_data(d0), .o_valid(v0), .o_phase(p0), .o_sync_err(e0));
  commutator_demux #(.gp_data_width(8), .gp_nr_phases(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena[1]), .i_valid(vld[1]), .i_sync(syn[1]),
    .i_data(din[1]), .o_data(d1), .o_valid(v1), .o_phase(p1), .o_sync_err(e1));
  commutator_demux #(.gp_data_width(8), .gp_nr_phases(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_ena(ena[2]), .i_valid(vld[2]), .i_sync(syn[2]),
    .i_data(din[2]), .o_data(d2), .o_valid(v2), .o_phase(p2), .o_sync_err(e2));

  // Reference model: collected samples per instance, frame built by shifting.
  int          nph [3] = '{4, 3, 2};
  int          cnt [3];
  logic [7:0]  lanes [3][4];
  logic [31:0] exp_data [3];
  logic        exp_valid [3];
  logic        exp_err [3];

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  function automatic logic [31:0] obs_data(input int k);
    return (k == 0) ? d0 : (k == 1) ? 32'(d1) : 32'(d2);
  endfunction
  function automatic logic [31:0] obs_phase(input int k);
    return (k == 0) ? 32'(p0) : (k == 1) ? 32'(p1) : 32'(p2);
  endfunction
  function automatic logic obs_valid(input int k);
    return (k == 0) ? v0 : (k == 1) ? v1 : v2;
  endfunction
  function automatic logic obs_err(input int k);
    return (k == 0) ? e0 : (k == 1) ? e1 : e2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      cnt[k] = 0;
      exp_data[k] = '0;
      exp_valid[k] = 1'b0;
      exp_err[k] = 1'b0;
      for (int i = 0; i < 4; i++) lanes[k][i] = '0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      exp_valid[k] = 1'b0;
      if (ena[k]) begin
        if (syn[k]) begin
          if (cnt[k] != 0) exp_err[k] = 1'b1;
          cnt[k] = 0;
        end
        if (vld[k]) begin
          lanes[k][cnt[k]] = din[k];
          cnt[k]++;
          if (cnt[k] == nph[k]) begin
            exp_data[k] = '0;
            for (int i = 0; i < nph[k]; i++) exp_data[k] = exp_data[k] | (32'(lanes[k][i]) << (8 * i));
            exp_valid[k] = 1'b1;
            cnt[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string where);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_n%0d_data", where, nph[k]), obs_data(k), exp_data[k]);
      chk($sformatf("%s_n%0d_valid", where, nph[k]), 32'(obs_valid(k)), 32'(exp_valid[k]));
      chk($sformatf("%s_n%0d_phase", where, nph[k]), obs_phase(k), 32'(cnt[k]));
      chk($sformatf("%s_n%0d_err", where, nph[k]), 32'(obs_err(k)), 32'(exp_err[k]));
    end
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin
      ena[k] = 1'b1; vld[k] = 1'b0; syn[k] = 1'b0; din[k] = '0;
    end
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_step();
    #1;
    check_all(where);
    idle();
  endtask

  task automatic send(input int k, input logic [7:0] v);
    vld[k] = 1'b1; din[k] = v;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1;
    apply_reset();

    // Four-lane frame of consecutive samples.
    send(0, 8'h11); step("f4");
    send(0, 8'h22); step("f4");
    send(0, 8'h33); step("f4");
    send(0, 8'h44); step("f4");
    chk("f4_frame", d0, 32'h44332211);
    chk("f4_pulse", 32'(v0), 32'd1);
    chk("f4_phase0", 32'(p0), 32'd0);
    step("f4_after");
    chk("f4_pulse_drop", 32'(v0), 32'd0);
    chk("f4_hold", d0, 32'h44332211);

    // Three-lane frames with irregular gaps.
    for (int s = 1; s <= 6; s++) begin
      send(1, 8'(s)); step("f3");
      for (int g = 0; g < (s % 3); g++) step("f3_gap");
      if (s == 3) chk("f3_frame1", 32'(d1), 32'h00030201);
    end
    chk("f3_frame2", 32'(d1), 32'h00060504);

    // Enable dropped on the third sample.
    send(0, 8'hA1); step("ena");
    send(0, 8'hA2); step("ena");
    send(0, 8'hA3); ena[0] = 1'b0; step("ena_off");
    chk("ena_stall", 32'(p0), 32'd2);
    send(0, 8'hA4); step("ena");
    send(0, 8'hA5); step("ena");
    chk("ena_frame", d0, 32'hA5A4A2A1);

    // Sync at phase 2 with a coincident sample.
    send(0, 8'h01); step("sync");
    send(0, 8'h02); step("sync");
    send(0, 8'hAA); syn[0] = 1'b1; step("sync_hit");
    chk("sync_phase", 32'(p0), 32'd1);
    chk("sync_err", 32'(e0), 32'd1);
    chk("sync_data_kept", d0, 32'hA5A4A2A1);
    send(0, 8'hBB); step("sync");
    send(0, 8'hCC); step("sync");
    send(0, 8'hDD); step("sync");
    chk("sync_lane0", d0, 32'hDDCCBBAA);
    chk("sync_err_sticky", 32'(e0), 32'd1);

    // Reset in the middle of a frame.
    send(0, 8'h51); step("mid");
    send(0, 8'h52); step("mid");
    apply_reset();
    chk("rst_err_clear", 32'(e0), 32'd0);
    send(0, 8'h61); step("post");
    send(0, 8'h62); step("post");
    send(0, 8'h63); step("post");
    send(0, 8'h64); step("post");
    chk("post_frame", d0, 32'h64636261);

    // Two lanes, back-to-back samples.
    pulses = 0;
    for (int s = 0; s < 20; s++) begin
      send(2, 8'(8'h80 + s)); step("f2");
      if (v2) pulses++;
    end
    chk("f2_pulses", 32'(pulses), 32'd10);
    chk("f2_last", 32'(d2), 32'h00009392);

    // Random traffic on every instance.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        ena[k] = ($urandom_range(0, 7) != 0);
        vld[k] = ($urandom_range(0, 2) != 0);
        syn[k] = ($urandom_range(0, 24) == 0);
        din[k] = 8'($urandom);
      end
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
